// File: rtl/regfile_pkg.sv
// Shared defaults and constants for the multi-read-port register file.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_READ = 2;
    localparam int MAX_READ     = 4;
    localparam int ZERO_REG     = 0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: storage mux, zero-register forcing and, when
// REGFILE_BYPASS_EN is defined, write-through forwarding of the in-flight write.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic [ADDR_W-1:0]             raddr,
    input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
    input  logic [DEPTH-1:0]              busy,
    input  logic                          wen,
    input  logic [ADDR_W-1:0]             waddr,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             rdata,
    output logic                          rbusy
);

    logic is_zero;
    assign is_zero = (raddr == ADDR_W'(ZERO_REG));

`ifdef REGFILE_BYPASS_EN
    logic hit;
    // wen already excludes register 0 and reset, so a hit is always a real write
    assign hit = wen && (raddr == waddr);

    always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        if (hit) begin
            rdata = wdata;
        end else if (!is_zero) begin
            rdata = mem[raddr];
            rbusy = busy[raddr];
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{wen, waddr, wdata};

    always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        if (!is_zero) begin
            rdata = mem[raddr];
            rbusy = busy[raddr];
        end
    end
`endif

endmodule

// File: rtl/registerfile_mp.sv
// Parametrised register file: NUM_READ combinational read ports, one write port,
// hardwired r0 and a busy scoreboard. Optional forwarding via REGFILE_BYPASS_EN.
module registerfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_READ = DEF_NUM_READ
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_READ*ADDR_W-1:0]   ReadAddr,
    output logic [NUM_READ*DATA_W-1:0]   ReadData,
    output logic [NUM_READ-1:0]          ReadBusy,
    input  logic [ADDR_W-1:0]            WriteReg,
    input  logic [DATA_W-1:0]            WriteData,
    input  logic                         RegWrite,
    input  logic [ADDR_W-1:0]            IssueReg,
    input  logic                         IssueValid,
    output logic [(1<<ADDR_W)-1:0]       BusyVec
);

    localparam int DEPTH = 1 << ADDR_W;

    if (NUM_READ < 1 || NUM_READ > MAX_READ) begin : g_bad_num_read
        $error("registerfile_mp: NUM_READ must be in 1..4");
    end

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DEPTH-1:0]             busy;
    logic                         wen;
    logic                         ien;

    assign wen = RegWrite && (WriteReg != ADDR_W'(ZERO_REG)) && !reset;
    assign ien = IssueValid && (IssueReg != ADDR_W'(ZERO_REG));

    // Issue is applied after the write so a same-edge issue leaves the register busy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem  <= '0;
            busy <= '0;
        end else begin
            if (wen) begin
                mem[WriteReg]  <= WriteData;
                busy[WriteReg] <= 1'b0;
            end
            if (ien) begin
                busy[IssueReg] <= 1'b1;
            end
        end
    end

    assign BusyVec = busy;

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        regfile_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_rd (
            .raddr (ReadAddr[k*ADDR_W +: ADDR_W]),
            .mem   (mem),
            .busy  (busy),
            .wen   (wen),
            .waddr (WriteReg),
            .wdata (WriteData),
            .rdata (ReadData[k*DATA_W +: DATA_W]),
            .rbusy (ReadBusy[k])
        );
    end

endmodule

// File: tb/tb_registerfile_mp.sv
// Directed bench for registerfile_mp: per-cycle model compare on the default
// instance plus literal checks, and a 4-port 8x16 instance for parameter coverage.
module tb_registerfile_mp;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [9:0]  ReadAddr;
    logic [63:0] ReadData;
    logic [1:0]  ReadBusy;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [4:0]  IssueReg;
    logic        IssueValid;
    logic [31:0] BusyVec;

    logic [11:0] b_raddr;
    logic [63:0] b_rdata;
    logic [3:0]  b_rbusy;
    logic [2:0]  b_wreg;
    logic [15:0] b_wdata;
    logic        b_we;
    logic [2:0]  b_ireg;
    logic        b_iv;
    logic [7:0]  b_busy;

    int checks = 0;
    int failures = 0;

    registerfile_mp u_dut (
        .clock(clock), .reset(reset),
        .ReadAddr(ReadAddr), .ReadData(ReadData), .ReadBusy(ReadBusy),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
        .IssueReg(IssueReg), .IssueValid(IssueValid), .BusyVec(BusyVec)
    );

    registerfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_READ(4)) u_dut4 (
        .clock(clock), .reset(reset),
        .ReadAddr(b_raddr), .ReadData(b_rdata), .ReadBusy(b_rbusy),
        .WriteReg(b_wreg), .WriteData(b_wdata), .RegWrite(b_we),
        .IssueReg(b_ireg), .IssueValid(b_iv), .BusyVec(b_busy)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Architectural state of the default instance
    logic [31:0] mdata [32];
    bit          mbusy [32];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mdata[i] = '0;
                mbusy[i] = 1'b0;
            end
        end else begin
            if (RegWrite && WriteReg != 0) begin
                mdata[WriteReg] = WriteData;
                mbusy[WriteReg] = 1'b0;
            end
            if (IssueValid && IssueReg != 0) mbusy[IssueReg] = 1'b1;
        end
    end

    function automatic logic fwd(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
        return !reset && RegWrite && WriteReg != 0 && WriteReg == a;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (fwd(a)) return WriteData;
        return mdata[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0 || fwd(a)) return 1'b0;
        return mbusy[a];
    endfunction

    always @(negedge clock) begin
        logic [31:0] bv;
        logic [4:0]  a;
        for (int k = 0; k < 2; k++) begin
            a = ReadAddr[k*5 +: 5];
            chk($sformatf("model_rdata%0d", k), 64'(ReadData[k*32 +: 32]), 64'(exp_data(a)));
            chk($sformatf("model_rbusy%0d", k), 64'(ReadBusy[k]), 64'(exp_busy(a)));
        end
        for (int i = 0; i < 32; i++) bv[i] = mbusy[i];
        chk("model_busyvec", 64'(BusyVec), 64'(bv));
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        ReadAddr = '0; WriteReg = '0; WriteData = '0; RegWrite = 1'b0;
        IssueReg = '0; IssueValid = 1'b0;
        b_raddr = '0; b_wreg = '0; b_wdata = '0; b_we = 1'b0; b_ireg = '0; b_iv = 1'b0;
        reset = 1'b1;
        step();
        step();
        chk("reset_rdata", ReadData, 64'h0);
        chk("reset_busyvec", 64'(BusyVec), 64'h0);
        reset = 1'b0;
        step();

        // write/read
        RegWrite = 1'b1; WriteReg = 5'd1; WriteData = 32'hFFFF_FFFF;
        step();
        RegWrite = 1'b0; ReadAddr = {5'd2, 5'd1};
        #1;
        chk("wr_r1_p0", 64'(ReadData[31:0]), 64'hFFFF_FFFF);
        chk("wr_r1_p1_r2", 64'(ReadData[63:32]), 64'h0);

        // register 0 ignores writes and issues
        RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h1234_5678;
        IssueValid = 1'b1; IssueReg = 5'd0;
        step();
        RegWrite = 1'b0; IssueValid = 1'b0; ReadAddr = {5'd1, 5'd0};
        #1;
        chk("r0_data", 64'(ReadData[31:0]), 64'h0);
        chk("r0_busy", 64'(ReadBusy[0]), 64'h0);
        chk("r0_busyvec", 64'(BusyVec[0]), 64'h0);

        // scoreboard
        IssueValid = 1'b1; IssueReg = 5'd7; ReadAddr = {5'd1, 5'd7};
        #1;
        chk("issue_same_cycle", 64'(ReadBusy[0]), 64'h0);
        step();
        IssueValid = 1'b0;
        #1;
        chk("issue_busy_next", 64'(ReadBusy[0]), 64'h1);
        chk("issue_busyvec", 64'(BusyVec), 64'h0000_0080);
        RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h0000_00A5;
        step();
        RegWrite = 1'b0;
        #1;
        chk("wb_r7_data", 64'(ReadData[31:0]), 64'hA5);
        chk("wb_r7_busy", 64'(ReadBusy[0]), 64'h0);
        IssueValid = 1'b1; IssueReg = 5'd7;
        RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h0000_0077;
        step();
        IssueValid = 1'b0; RegWrite = 1'b0;
        #1;
        chk("iss_wr_busy", 64'(ReadBusy[0]), 64'h1);
        chk("iss_wr_data", 64'(ReadData[31:0]), 64'h77);

        // forwarding window on r3 (busy first so the busy override is visible)
        IssueValid = 1'b1; IssueReg = 5'd3;
        step();
        IssueValid = 1'b0;
        ReadAddr = {5'd3, 5'd7};
        RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h55;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_data", 64'(ReadData[63:32]), 64'h55);
        chk("byp_busy", 64'(ReadBusy[1]), 64'h0);
`else
        chk("nobyp_data", 64'(ReadData[63:32]), 64'h0);
        chk("nobyp_busy", 64'(ReadBusy[1]), 64'h1);
`endif
        step();
        RegWrite = 1'b0;
        #1;
        chk("r3_next", 64'(ReadData[63:32]), 64'h55);
        chk("r3_busy_next", 64'(ReadBusy[1]), 64'h0);

        // async reset between edges discards the pending write
        RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEAD_BEEF;
        step();
        ReadAddr = {5'd6, 5'd5};
        WriteReg = 5'd6; WriteData = 32'hCAFE_F00D;
        #1;
        chk("r5_loaded", 64'(ReadData[31:0]), 64'hDEAD_BEEF);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_r5", 64'(ReadData[31:0]), 64'h0);
        chk("async_rst_busyvec", 64'(BusyVec), 64'h0);
        @(posedge clock);
        #3;
        reset = 1'b0; RegWrite = 1'b0;
        #1;
        chk("rst_discard_r6", 64'(ReadData[63:32]), 64'h0);
        chk("rst_r7_cleared", 64'(u_dut.BusyVec[7]), 64'h0);
        step();

        // 4 ports, 8 x 16
        for (int r = 1; r <= 4; r++) begin
            b_we = 1'b1; b_wreg = 3'(r); b_wdata = 16'(r * 16'h1111);
            step();
        end
        b_wreg = 3'd7; b_wdata = 16'h7777;
        step();
        b_we = 1'b0;
        b_raddr = {3'd4, 3'd3, 3'd2, 3'd1};
        #1;
        chk("p4_r1", 64'(b_rdata[15:0]),  64'h1111);
        chk("p4_r2", 64'(b_rdata[31:16]), 64'h2222);
        chk("p4_r3", 64'(b_rdata[47:32]), 64'h3333);
        chk("p4_r4", 64'(b_rdata[63:48]), 64'h4444);
        b_raddr = {3'd3, 3'd6, 3'd0, 3'd7};
        #1;
        chk("p4_r7", 64'(b_rdata[15:0]),  64'h7777);
        chk("p4_r0", 64'(b_rdata[31:16]), 64'h0);
        chk("p4_r6", 64'(b_rdata[47:32]), 64'h0);
        chk("p4_r3_intact", 64'(b_rdata[63:48]), 64'h3333);
        b_iv = 1'b1; b_ireg = 3'd7;
        step();
        b_iv = 1'b0;
        #1;
        chk("p4_busy", 64'(b_rbusy), 64'h1);
        chk("p4_busyvec", 64'(b_busy), 64'h80);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
